// File: rtl/iob_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_cfg_pkg
// Description : Shared types, constants and byte check for the IOB config loader.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_cfg_pkg;

    localparam int IOB_CFG_W = 8;
    localparam logic [IOB_CFG_W-1:0] IOB_CFG_SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_CHECK = 3'd4
    } cfg_state_e;

    // Clearing the lowest set bit leaves zero only for 0 or 1 bits set.
    function automatic logic at_most_one_hot(input logic [IOB_CFG_W-1:0] b);
        return (b & (b - 8'd1)) == 8'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_cfg_shift.sv
`default_nettype none
// ============================================================================
// Module      : iob_cfg_shift
// Description : Serial-in shadow register with per-byte XOR accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_cfg_shift
    import iob_cfg_pkg::*;
#(
    parameter int NUM_IOB = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           shift_en,
    input  logic                           din,
    output logic [NUM_IOB*IOB_CFG_W-1:0]   shadow,
    output logic [IOB_CFG_W-1:0]           acc
);

    localparam int c_SHADOW_W = NUM_IOB * IOB_CFG_W;

    logic [IOB_CFG_W-2:0]  r_part;
    logic [2:0]            r_bit_cnt;
    logic [c_SHADOW_W-1:0] r_shadow;
    logic [IOB_CFG_W-1:0]  r_acc;
    logic [IOB_CFG_W-1:0]  w_byte;
    logic [c_SHADOW_W-1:0] w_shadow_ins;

    assign w_byte = {r_part, din};

    // Completed bytes enter at the top, so the first byte ends in the lowest lane.
    if (NUM_IOB == 1) begin : g_single
        assign w_shadow_ins = w_byte;
    end else begin : g_multi
        assign w_shadow_ins = {w_byte, r_shadow[c_SHADOW_W-1:IOB_CFG_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_part    <= '0;
            r_bit_cnt <= '0;
            r_shadow  <= '0;
            r_acc     <= '0;
        end else if (clr) begin
            r_part    <= '0;
            r_bit_cnt <= '0;
            r_shadow  <= '0;
            r_acc     <= '0;
        end else if (shift_en) begin
            r_part    <= w_byte[IOB_CFG_W-2:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
                r_shadow <= w_shadow_ins;
                r_acc    <= r_acc ^ w_byte;
            end
        end
    end

    assign shadow = r_shadow;
    assign acc    = r_acc;

endmodule
`default_nettype wire

// File: rtl/iob_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : iob_cfg_loader
// Description : Framed serial loader for IOB switch controls with sync word,
//               XOR checksum and atomic commit. IOB_CFG_ONEHOT_EN adds a
//               per-byte at-most-one-bit check before commit.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_cfg_loader
    import iob_cfg_pkg::*;
#(
    parameter int                   NUM_IOB   = 4,
    parameter logic [IOB_CFG_W-1:0] SYNC_WORD = IOB_CFG_SYNC_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    input  logic                         cfg_din,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    output logic [NUM_IOB*IOB_CFG_W-1:0] sram_con_bit,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_err
);

    localparam int c_CFG_W = NUM_IOB * IOB_CFG_W;
    localparam int c_CNT_W = $clog2(c_CFG_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_BYTE_LAST = IOB_CFG_W - 1;
    localparam logic [c_CNT_W-1:0] c_LOAD_LAST = c_CFG_W - 1;

    cfg_state_e           r_state;
    cfg_state_e           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [IOB_CFG_W-1:0] r_word;
    logic [IOB_CFG_W-1:0] w_word_nxt;
    logic [IOB_CFG_W-1:0] w_word_shift;
    logic [c_CFG_W-1:0]   r_sram;
    logic                 r_done;
    logic                 r_err;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_clr;
    logic                 w_shift_en;
    logic                 w_commit;
    logic                 w_fail;
    logic                 w_onehot_ok;
    logic [c_CFG_W-1:0]   w_shadow;
    logic [IOB_CFG_W-1:0] w_acc;

    iob_cfg_shift #(
        .NUM_IOB (NUM_IOB)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_clr),
        .shift_en (w_shift_en),
        .din      (cfg_din),
        .shadow   (w_shadow),
        .acc      (w_acc)
    );

`ifdef IOB_CFG_ONEHOT_EN
    logic [NUM_IOB-1:0] w_byte_ok;
    for (genvar gi = 0; gi < NUM_IOB; gi++) begin : g_onehot
        assign w_byte_ok[gi] = at_most_one_hot(w_shadow[gi*IOB_CFG_W +: IOB_CFG_W]);
    end
    assign w_onehot_ok = &w_byte_ok;
`else
    assign w_onehot_ok = 1'b1;
`endif

    assign w_ready      = (r_state == ST_SYNC) || (r_state == ST_LOAD) || (r_state == ST_CSUM);
    // A start pulse always wins over a coincident data bit.
    assign w_accept     = cfg_valid && w_ready && !cfg_start;
    assign w_word_shift = {r_word[IOB_CFG_W-2:0], cfg_din};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_clr       = 1'b0;
        w_shift_en  = 1'b0;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        if (cfg_start) begin
            w_state_nxt = ST_SYNC;
            w_cnt_nxt   = '0;
            w_word_nxt  = '0;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_SYNC: begin
                    if (w_accept) begin
                        w_word_nxt = w_word_shift;
                        if (r_cnt == c_BYTE_LAST) begin
                            w_cnt_nxt = '0;
                            if (w_word_shift == SYNC_WORD) begin
                                w_state_nxt = ST_LOAD;
                            end else begin
                                w_fail      = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        w_shift_en = 1'b1;
                        if (r_cnt == c_LOAD_LAST) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_CSUM;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_accept) begin
                        w_word_nxt = w_word_shift;
                        if (r_cnt == c_BYTE_LAST) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_CHECK;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                end
                ST_CHECK: begin
                    w_state_nxt = ST_IDLE;
                    if ((r_word == w_acc) && w_onehot_ok) begin
                        w_commit = 1'b1;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_sram  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_done  <= w_commit;
            if (w_commit) begin
                r_sram <= w_shadow;
            end
            if (w_clr) begin
                r_err <= 1'b0;
            end else if (w_fail) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cfg_ready    = w_ready;
    assign cfg_busy     = (r_state != ST_IDLE);
    assign cfg_done     = r_done;
    assign cfg_err      = r_err;
    assign sram_con_bit = r_sram;

endmodule
`default_nettype wire

// File: tb/tb_iob_cfg_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_iob_cfg_loader
// Description : Self-checking bench for iob_cfg_loader with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_din = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] sram_con_bit;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_done_pulses = 0;
    bit sim_end = 1'b0;

    // Frame-level expectations, updated by the driver just after each edge
    logic [31:0] m_sram  = 32'h0;
    logic        m_ready = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_err   = 1'b0;

    always #5 clk = ~clk;

    iob_cfg_loader #(
        .NUM_IOB   (4),
        .SYNC_WORD (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_din      (cfg_din),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .sram_con_bit (sram_con_bit),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!sim_end) begin
            check("sram_con_bit", sram_con_bit, m_sram);
            check("cfg_ready", {31'b0, cfg_ready}, {31'b0, m_ready});
            check("cfg_busy",  {31'b0, cfg_busy},  {31'b0, m_busy});
            check("cfg_done",  {31'b0, cfg_done},  {31'b0, m_done});
            check("cfg_err",   {31'b0, cfg_err},   {31'b0, m_err});
        end
    end

    always @(negedge clk) begin
        if (cfg_done === 1'b1) n_done_pulses++;
    end

    function automatic logic [7:0] frame_xor(input logic [31:0] d);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4; i++) x ^= d[i*8 +: 8];
        return x;
    endfunction

    function automatic bit bytes_ok(input logic [31:0] d);
        bit ok = 1'b1;
`ifdef IOB_CFG_ONEHOT_EN
        for (int i = 0; i < 4; i++) if ($countones(d[i*8 +: 8]) > 1) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic pulse_start(input bit with_valid);
        cfg_start = 1'b1;
        cfg_valid = with_valid;
        cfg_din   = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        m_busy = 1'b1; m_ready = 1'b1; m_err = 1'b0; m_done = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            int n;
            n = int'($urandom_range(1, 5));
            repeat (n) begin
                cfg_valid = 1'b0;
                cfg_din   = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        cfg_valid = 1'b1;
        cfg_din   = b;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
    endtask

    task automatic run_frame(input logic [7:0] sync, input logic [31:0] data,
                             input logic [7:0] csum, input bit gaps, input bit start_valid);
        pulse_start(start_valid);
        send_byte(sync, gaps);
        if (sync != 8'hA5) begin
            m_busy = 1'b0; m_ready = 1'b0; m_err = 1'b1;
            return;
        end
        for (int i = 0; i < 4; i++) send_byte(data[i*8 +: 8], gaps);
        send_byte(csum, gaps);
        m_ready = 1'b0;
        @(posedge clk); #1;
        m_busy = 1'b0;
        if ((csum == frame_xor(data)) && bytes_ok(data)) begin
            m_sram = data;
            m_done = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        @(posedge clk); #1;
        m_done = 1'b0;
    endtask

    task automatic partial_frame(input int load_bits);
        pulse_start(1'b0);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < load_bits; i++) send_bit(1'(i % 3 != 0), 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset sram", sram_con_bit, 32'h0);
        check("reset ready", {31'b0, cfg_ready}, 32'h0);
        check("reset busy", {31'b0, cfg_busy}, 32'h0);
        check("reset done", {31'b0, cfg_done}, 32'h0);
        check("reset err", {31'b0, cfg_err}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset ready", {31'b0, cfg_ready}, 32'h0);

        d0 = n_done_pulses;
        run_frame(8'hA5, 32'h80040201, 8'h87, 1'b0, 1'b0);
        check("good sram", sram_con_bit, 32'h80040201);
        check("good err", {31'b0, cfg_err}, 32'h0);
        check("good done count", n_done_pulses - d0, 1);

        run_frame(8'hA4, 32'h11223344, 8'h00, 1'b0, 1'b0);
        check("bad sync err", {31'b0, cfg_err}, 32'h1);
        check("bad sync sram", sram_con_bit, 32'h80040201);

        d0 = n_done_pulses;
        run_frame(8'hA5, 32'h80040201, 8'h86, 1'b0, 1'b0);
        check("bad csum err", {31'b0, cfg_err}, 32'h1);
        check("bad csum sram", sram_con_bit, 32'h80040201);
        check("bad csum done count", n_done_pulses - d0, 0);

        d0 = n_done_pulses;
        partial_frame(12);
        run_frame(8'hA5, 32'h08402010, 8'h78, 1'b0, 1'b1);
        check("abort sram", sram_con_bit, 32'h08402010);
        check("abort err", {31'b0, cfg_err}, 32'h0);
        check("abort done count", n_done_pulses - d0, 1);

        d0 = n_done_pulses;
        run_frame(8'hA5, 32'h80040201, 8'h87, 1'b1, 1'b0);
        check("gap sram", sram_con_bit, 32'h80040201);
        check("gap done count", n_done_pulses - d0, 1);

        partial_frame(10);
        #2;
        rst_n = 1'b0;
        m_sram = 32'h0; m_busy = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_done = 1'b0;
        #1;
        check("mid reset sram", sram_con_bit, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after reset busy", {31'b0, cfg_busy}, 32'h0);

        run_frame(8'hA5, 32'h00000003, 8'h03, 1'b0, 1'b0);
`ifdef IOB_CFG_ONEHOT_EN
        check("onehot err", {31'b0, cfg_err}, 32'h1);
        check("onehot sram", sram_con_bit, 32'h0);
`else
        check("fanout err", {31'b0, cfg_err}, 32'h0);
        check("fanout sram", sram_con_bit, 32'h00000003);
`endif

        repeat (2) @(posedge clk);
        #1;
        sim_end = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
